// File: rtl/packet_replicator_pkg.sv
// Shared definitions for the packet replicator: FSM encoding and port-count limits.
package packet_replicator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  localparam int MIN_PORTS = 2;
  localparam int MAX_PORTS = 8;

endpackage

// File: rtl/replicator_port_slot.sv
// One replica output slot: a single-entry output register with valid flag,
// plus the per-port forwarded-packet and dropped-packet counters.
module replicator_port_slot
  import packet_replicator_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int USER_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   ld_tdata,
  input  logic [DATA_WIDTH/8-1:0] ld_tstrb,
  input  logic [USER_WIDTH-1:0]   ld_tuser,
  input  logic                    ld_tlast,
  input  logic                    tready,
  input  logic                    drop_inc,
  input  logic                    cnt_clear,
  output logic [DATA_WIDTH-1:0]   tdata,
  output logic [DATA_WIDTH/8-1:0] tstrb,
  output logic [USER_WIDTH-1:0]   tuser,
  output logic                    tlast,
  output logic                    tvalid,
  output logic                    free,
  output logic [CNT_WIDTH-1:0]    pkt_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt
);

  logic pkt_inc;

  // Slot can take a new beat when empty or when its current beat leaves this cycle.
  always_comb begin
    free    = !tvalid || tready;
    pkt_inc = tvalid && tlast && tready;
  end

  // Valid flag: set on load, cleared once the downstream takes the beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

  // Beat payload register; contents are don't-care while tvalid is low.
  always_ff @(posedge clk) begin
    if (load) begin
      tdata <= ld_tdata;
      tstrb <= ld_tstrb;
      tuser <= ld_tuser;
      tlast <= ld_tlast;
    end
  end

  // Saturating packet counter; clear takes priority over an increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      pkt_cnt <= '0;
    end else if (pkt_inc && (pkt_cnt != '1)) begin
      pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

  // Saturating drop counter; clear takes priority over an increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      drop_cnt <= '0;
    end else if (drop_inc && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/packet_replicator.sv
// Replicates one AXI-Stream packet flow onto NUM_PORTS master ports. Lockstep
// ports stall the source; best-effort ports busy at the first beat skip the packet.
module packet_replicator
  import packet_replicator_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 4,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                                        axi_aclk,
  input  logic                                        axi_areset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]                s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]              s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]               s_axis_tuser,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic                                        s_axis_tlast,
  output logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic [NUM_PORTS-1:0]                        m_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                        m_axis_tready,
  output logic [NUM_PORTS-1:0]                        m_axis_tlast,
  input  logic [NUM_PORTS-1:0]                        en_mask,
  input  logic [NUM_PORTS-1:0]                        be_mask,
  input  logic                                        cnt_clear,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]              pkt_cnt,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]              drop_cnt
);

  localparam int STRB_WIDTH = C_AXIS_DATA_WIDTH / 8;

  if (NUM_PORTS < MIN_PORTS || NUM_PORTS > MAX_PORTS) begin : g_bad_num_ports
    $error("packet_replicator: NUM_PORTS out of range");
  end

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] act_q;
  logic [NUM_PORTS-1:0] free;
  logic [NUM_PORTS-1:0] cand;
  logic [NUM_PORTS-1:0] use_mask;
  logic [NUM_PORTS-1:0] load;
  logic [NUM_PORTS-1:0] drop_inc;
  logic                 accept;

  // Port selection, source handshake and next state. In IDLE the mask is the
  // live candidate; mid-packet it is the mask frozen at the first beat.
  always_comb begin
    cand          = en_mask & (~be_mask | free);
    use_mask      = (state_q == IDLE) ? cand : act_q;
    s_axis_tready = !axi_areset && ((use_mask & ~free) == '0);
    accept        = s_axis_tvalid && s_axis_tready;
    load          = {NUM_PORTS{accept}} & use_mask;
    drop_inc      = '0;
    if (accept && (state_q == IDLE) && (cand != '0)) begin
      drop_inc = en_mask & be_mask & ~free;
    end
    state_d = state_q;
    if (accept) begin
      state_d = s_axis_tlast ? IDLE : PKT;
    end
  end

  // FSM state and packet-wide active mask.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q <= IDLE;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept && (state_q == IDLE)) begin
        act_q <= cand;
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
    replicator_port_slot #(
      .DATA_WIDTH (C_AXIS_DATA_WIDTH),
      .USER_WIDTH (C_AXIS_TUSER_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_slot (
      .clk       (axi_aclk),
      .rst       (axi_areset),
      .load      (load[i]),
      .ld_tdata  (s_axis_tdata),
      .ld_tstrb  (s_axis_tstrb),
      .ld_tuser  (s_axis_tuser),
      .ld_tlast  (s_axis_tlast),
      .tready    (m_axis_tready[i]),
      .drop_inc  (drop_inc[i]),
      .cnt_clear (cnt_clear),
      .tdata     (m_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH]),
      .tstrb     (m_axis_tstrb[i*STRB_WIDTH +: STRB_WIDTH]),
      .tuser     (m_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH]),
      .tlast     (m_axis_tlast[i]),
      .tvalid    (m_axis_tvalid[i]),
      .free      (free[i]),
      .pkt_cnt   (pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH]),
      .drop_cnt  (drop_cnt[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_packet_replicator.sv
// Directed per-cycle vector bench for packet_replicator (4 ports, 4-bit counters).
module tb_packet_replicator;

  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int UW = 8;
  localparam int NP = 4;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              axi_areset;
  logic [DW-1:0]     s_axis_tdata;
  logic [SW-1:0]     s_axis_tstrb;
  logic [UW-1:0]     s_axis_tuser;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [NP*DW-1:0]  m_axis_tdata;
  logic [NP*SW-1:0]  m_axis_tstrb;
  logic [NP*UW-1:0]  m_axis_tuser;
  logic [NP-1:0]     m_axis_tvalid;
  logic [NP-1:0]     m_axis_tready;
  logic [NP-1:0]     m_axis_tlast;
  logic [NP-1:0]     en_mask;
  logic [NP-1:0]     be_mask;
  logic              cnt_clear;
  logic [NP*CW-1:0]  pkt_cnt;
  logic [NP*CW-1:0]  drop_cnt;

  always #5 clk = ~clk;

  packet_replicator #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .NUM_PORTS          (NP),
    .CNT_WIDTH          (CW)
  ) dut (
    .axi_aclk      (clk),
    .axi_areset    (axi_areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .en_mask       (en_mask),
    .be_mask       (be_mask),
    .cnt_clear     (cnt_clear),
    .pkt_cnt       (pkt_cnt),
    .drop_cnt      (drop_cnt)
  );

  typedef struct {
    logic        rst, vld, last, clr;
    logic [7:0]  tag;
    logic [3:0]  en, be, rdy;
    logic        srdy;
    logic [3:0]  mvld, dmask;
    logic [7:0]  etag;
    logic        chk;
    logic [15:0] epkt, edrop;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nmiss = 0;

  function automatic logic [DW-1:0] mk_data(input logic [7:0] t);
    return {t, ~t, t, ~t};
  endfunction

  // Argument order: rst vld tag last en be rdy clr | srdy mvld dmask etag | chk epkt edrop
  function automatic vec_t v(input int rst, input int vld, input int tag, input int last,
                             input int en, input int be, input int rdy, input int clr,
                             input int srdy, input int mvld, input int dmask, input int etag,
                             input int chk, input int epkt, input int edrop);
    vec_t r;
    r.rst = (rst != 0);   r.vld = (vld != 0);   r.last = (last != 0); r.clr = (clr != 0);
    r.tag = 8'(tag);      r.en = 4'(en);        r.be = 4'(be);        r.rdy = 4'(rdy);
    r.srdy = (srdy != 0); r.mvld = 4'(mvld);    r.dmask = 4'(dmask);  r.etag = 8'(etag);
    r.chk = (chk != 0);   r.epkt = 16'(epkt);   r.edrop = 16'(edrop);
    return r;
  endfunction

  task automatic step(input vec_t x, input int idx);
    @(negedge clk);
    axi_areset    = x.rst;
    s_axis_tvalid = x.vld;
    s_axis_tdata  = mk_data(x.tag);
    s_axis_tstrb  = x.tag[3:0];
    s_axis_tuser  = x.tag;
    s_axis_tlast  = x.last;
    en_mask       = x.en;
    be_mask       = x.be;
    m_axis_tready = x.rdy;
    cnt_clear     = x.clr;
    #1;
    nvec++;
    if (s_axis_tready !== x.srdy) begin
      nmiss++;
      $display("FAIL vec %0d s_axis_tready: got %b want %b", idx, s_axis_tready, x.srdy);
    end
    if (m_axis_tvalid !== x.mvld) begin
      nmiss++;
      $display("FAIL vec %0d m_axis_tvalid: got %b want %b", idx, m_axis_tvalid, x.mvld);
    end
    for (int p = 0; p < NP; p++) begin
      if (x.dmask[p]) begin
        if (m_axis_tdata[p*DW +: DW] !== mk_data(x.etag) ||
            m_axis_tuser[p*UW +: UW] !== x.etag ||
            m_axis_tstrb[p*SW +: SW] !== x.etag[3:0]) begin
          nmiss++;
          $display("FAIL vec %0d port%0d beat: got data %h user %h strb %h want data %h user %h strb %h",
                   idx, p, m_axis_tdata[p*DW +: DW], m_axis_tuser[p*UW +: UW],
                   m_axis_tstrb[p*SW +: SW], mk_data(x.etag), x.etag, x.etag[3:0]);
        end
      end
    end
    if (x.chk) begin
      if (pkt_cnt !== x.epkt) begin
        nmiss++;
        $display("FAIL vec %0d pkt_cnt: got %h want %h", idx, pkt_cnt, x.epkt);
      end
      if (drop_cnt !== x.edrop) begin
        nmiss++;
        $display("FAIL vec %0d drop_cnt: got %h want %h", idx, drop_cnt, x.edrop);
      end
    end
  endtask

  initial begin
    axi_areset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tstrb = '0;
    s_axis_tuser = '0; s_axis_tlast = 1'b0; en_mask = '1; be_mask = '0;
    m_axis_tready = '1; cnt_clear = 1'b0;
    repeat (2) @(posedge clk);

    // reset state, tready held low during reset
    tbl.push_back(v(1,1,'h00,0,'hF,0,'hF,0, 0,'h0,'h0,'h00, 1,'h0000,'h0000));
    // 3-beat lockstep packet to all ports
    tbl.push_back(v(0,1,'hA1,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 0,0,0));
    tbl.push_back(v(0,1,'hA2,0,'hF,0,'hF,0, 1,'hF,'hF,'hA1, 0,0,0));
    tbl.push_back(v(0,1,'hA3,1,'hF,0,'hF,0, 1,'hF,'hF,'hA2, 0,0,0));
    tbl.push_back(v(0,0,'h00,0,'hF,0,'hF,0, 1,'hF,'hF,'hA3, 1,'h0000,'h0000));
    tbl.push_back(v(0,0,'h00,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 1,'h1111,'h0000));
    // port 2 back-pressures for 5 cycles mid-packet
    tbl.push_back(v(0,1,'hB1,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 0,0,0));
    tbl.push_back(v(0,1,'hB2,0,'hF,0,'hF,0, 1,'hF,'hF,'hB1, 0,0,0));
    tbl.push_back(v(0,1,'hB3,0,'hF,0,'hB,0, 0,'hF,'hF,'hB2, 0,0,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(v(0,1,'hB3,0,'hF,0,'hB,0, 0,'h4,'h4,'hB2, 0,0,0));
    tbl.push_back(v(0,1,'hB3,0,'hF,0,'hF,0, 1,'h4,'h4,'hB2, 0,0,0));
    tbl.push_back(v(0,1,'hB4,1,'hF,0,'hF,0, 1,'hF,'hF,'hB3, 0,0,0));
    tbl.push_back(v(0,0,'h00,0,'hF,0,'hF,0, 1,'hF,'hF,'hB4, 0,0,0));
    tbl.push_back(v(0,0,'h00,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 1,'h2222,'h0000));
    // best-effort port 2 busy at the first beat: skipped, others never stall
    tbl.push_back(v(0,1,'hC0,1,'hF,'h4,'hB,0, 1,'h0,'h0,'h00, 0,0,0));
    tbl.push_back(v(0,1,'hD1,0,'hF,'h4,'hB,0, 1,'hF,'hF,'hC0, 0,0,0));
    tbl.push_back(v(0,1,'hD2,0,'hF,'h4,'hB,0, 1,'hF,'hB,'hD1, 0,0,0));
    tbl.push_back(v(0,1,'hD3,1,'hF,'h4,'hB,0, 1,'hF,'hB,'hD2, 1,'h3233,'h0100));
    tbl.push_back(v(0,0,'h00,0,'hF,'h4,'hF,0, 1,'hF,'hB,'hD3, 0,0,0));
    tbl.push_back(v(0,0,'h00,0,'hF,'h4,'hF,0, 1,'h0,'h0,'h00, 1,'h4344,'h0100));
    // en_mask narrows mid-packet: current packet to all, next to port 0 only
    tbl.push_back(v(0,1,'hE1,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 0,0,0));
    tbl.push_back(v(0,1,'hE2,0,'h1,0,'hF,0, 1,'hF,'hF,'hE1, 0,0,0));
    tbl.push_back(v(0,1,'hE3,0,'h1,0,'hF,0, 1,'hF,'hF,'hE2, 0,0,0));
    tbl.push_back(v(0,1,'hE4,1,'h1,0,'hF,0, 1,'hF,'hF,'hE3, 0,0,0));
    tbl.push_back(v(0,1,'hF1,1,'h1,0,'hF,0, 1,'hF,'hF,'hE4, 0,0,0));
    tbl.push_back(v(0,0,'h00,0,'h1,0,'hF,0, 1,'h1,'h1,'hF1, 0,0,0));
    tbl.push_back(v(0,0,'h00,0,'h1,0,'hF,0, 1,'h0,'h0,'h00, 1,'h5456,'h0100));
    // empty active mask: packet consumed, counters unchanged
    tbl.push_back(v(0,1,'h61,0,'h0,0,'hF,0, 1,'h0,'h0,'h00, 0,0,0));
    tbl.push_back(v(0,1,'h62,1,'h0,0,'hF,0, 1,'h0,'h0,'h00, 0,0,0));
    tbl.push_back(v(0,0,'h00,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 1,'h5456,'h0100));
    // reset during beat 2 of 4, then a fresh single-beat packet
    tbl.push_back(v(0,1,'h71,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 0,0,0));
    tbl.push_back(v(1,1,'h72,0,'hF,0,'hF,0, 0,'hF,'hF,'h71, 0,0,0));
    tbl.push_back(v(0,0,'h00,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 1,'h0000,'h0000));
    tbl.push_back(v(0,1,'h51,1,'h3,0,'hF,0, 1,'h0,'h0,'h00, 0,0,0));
    tbl.push_back(v(0,0,'h00,0,'h3,0,'hF,0, 1,'h3,'h3,'h51, 0,0,0));
    tbl.push_back(v(0,0,'h00,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 1,'h0011,'h0000));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // saturation: 15 back-to-back single-beat packets drive every counter to all-ones
    for (int k = 0; k < 15; k++)
      step(v(0,1,'h80+k,1,'hF,0,'hF,0, 1,(k==0)?0:'hF,(k==0)?0:'hF,'h80+k-1, 0,0,0), 100+k);
    step(v(0,0,'h00,0,'hF,0,'hF,0, 1,'hF,'hF,'h8E, 0,0,0), 200);
    step(v(0,0,'h00,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 1,'hFFFF,'h0000), 201);
    // one more packet: counters stay saturated
    step(v(0,1,'h90,1,'hF,0,'hF,0, 1,'h0,'h0,'h00, 0,0,0), 202);
    step(v(0,0,'h00,0,'hF,0,'hF,0, 1,'hF,'hF,'h90, 0,0,0), 203);
    step(v(0,0,'h00,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 1,'hFFFF,'h0000), 204);
    // clear coincident with a tlast handshake: clear wins
    step(v(0,1,'h91,1,'hF,0,'hF,0, 1,'h0,'h0,'h00, 0,0,0), 205);
    step(v(0,0,'h00,0,'hF,0,'hF,1, 1,'hF,'hF,'h91, 0,0,0), 206);
    step(v(0,0,'h00,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 1,'h0000,'h0000), 207);
    // counting resumes after clear
    step(v(0,1,'h92,1,'hF,0,'hF,0, 1,'h0,'h0,'h00, 0,0,0), 208);
    step(v(0,0,'h00,0,'hF,0,'hF,0, 1,'hF,'hF,'h92, 0,0,0), 209);
    step(v(0,0,'h00,0,'hF,0,'hF,0, 1,'h0,'h0,'h00, 1,'h1111,'h0000), 210);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule

// File: doc/packet_replicator.md
PACKET_REPLICATOR -- requirements
Module: packet_replicator

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256: tdata width of slave and every master port.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128: tuser width of slave and every master port.
REQ-003 SHALL have parameter NUM_PORTS, default 4: number of master ports; legal range 2..8.
REQ-004 SHALL have parameter CNT_WIDTH, default 32: width of each statistics counter.
REQ-005 SHALL have port axi_aclk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port axi_areset, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have ports s_axis_tdata/tstrb/tuser/tvalid/tready/tlast, in/in/in/in/out/in, DATA/DATA/8/TUSER/1/1/1: the upstream packet stream.
REQ-008 SHALL have ports m_axis_tdata/tstrb/tuser/tvalid/tready/tlast, out/out/out/out/in/out, NUM_PORTS times each field width, flattened with port i at slice i: the replica streams.
REQ-009 SHALL have port en_mask, input, NUM_PORTS: port i receives packets when bit i is 1.
REQ-010 SHALL have port be_mask, input, NUM_PORTS: port i is best-effort when bit i is 1 and lockstep when bit i is 0.
REQ-011 SHALL have port cnt_clear, input, 1: single-cycle pulse that zeroes all counters.
REQ-012 SHALL have port pkt_cnt, output, NUM_PORTS*CNT_WIDTH: packets fully forwarded, per port.
REQ-013 SHALL have port drop_cnt, output, NUM_PORTS*CNT_WIDTH: packets skipped by best-effort exclusion, per port.

Function
REQ-014 Each master port SHALL have one output slot: a data register plus a valid flag. m_axis_tvalid[i] SHALL be the slot's valid flag only and SHALL never depend combinationally on any tready.
REQ-015 The slot of port i SHALL be "free" when its valid flag is 0 or m_axis_tready[i] is 1.
REQ-016 The FSM SHALL have two states: IDLE (awaiting first beat) and PKT (mid-packet).
REQ-017 In IDLE, a beat with s_axis_tvalid=1 SHALL latch the active mask.
- Lockstep port: active = en_mask[i].
- Best-effort port: active = en_mask[i] AND slot free that cycle.
REQ-018 s_axis_tready SHALL be 1 exactly when every port in the active mask has a free slot. In IDLE the candidate mask is used.
REQ-019 An accepted beat SHALL load into every active slot on the next edge, giving 1-cycle latency. tdata, tstrb, tuser and tlast SHALL be copied unmodified.
REQ-020 A beat accepted without tlast SHALL move the FSM IDLE->PKT. A beat accepted with tlast SHALL move it to IDLE; this includes single-beat packets accepted in IDLE.
REQ-021 Mask changes while in PKT SHALL be ignored until the next IDLE acceptance.
REQ-022 A best-effort port that is enabled but excluded at the first beat SHALL increment drop_cnt[i] once per packet. Once included, it SHALL behave as lockstep (stall) until tlast.
REQ-023 When the active mask is all zero, the packet SHALL be consumed (tready=1 every beat) and no counter SHALL change.
REQ-024 pkt_cnt[i] SHALL increment when a tlast beat leaves slot i, i.e. slot valid, tlast set and m_axis_tready[i]=1.
REQ-025 Counters SHALL saturate at all-ones.
REQ-026 If cnt_clear and an increment occur in the same cycle, clear SHALL win and the counter SHALL read 0.

Reset
REQ-027 On axi_aclk with axi_areset=1, the FSM SHALL go to IDLE and all slot valid flags SHALL clear, so every m_axis_tvalid=0.
REQ-028 On reset, the active mask and all counters SHALL clear to 0.
REQ-029 s_axis_tready SHALL be 0 while axi_areset=1.
REQ-030 Reset mid-packet SHALL discard the partial packet with no counter update. The next accepted beat SHALL be treated as a first beat.
REQ-031 Slot data registers need no reset.

Structure
REQ-032 A shared package packet_replicator_pkg SHALL hold:
- the FSM state encoding (IDLE=0, PKT=1);
- the port-count limits (2 and 8).
REQ-033 The per-port slot and its counters SHALL be one sub-module, replicator_port_slot, instantiated NUM_PORTS times by a generate loop.

Verification
REQ-034 NUM_PORTS=4, en_mask=4'b1111, be_mask=0, all tready=1; send a 3-beat packet -> each port emits 3 beats one cycle later with identical data; pkt_cnt=1 on all ports.
REQ-035 Same setup, hold m_axis_tready[2]=0 for 5 cycles mid-packet -> s_axis_tready=0 for those cycles; no beat lost or duplicated on any port; pkt_cnt=1 on all ports.
REQ-036 be_mask=4'b0100, port 2 slot full with tready=0 at the first beat -> ports 0, 1, 3 forward the packet; port 2 emits nothing; drop_cnt[2]=1; ports 0, 1, 3 never stall on port 2.
REQ-037 en_mask changes 4'b1111 -> 4'b0001 during beat 2 of 4 -> the current packet reaches all 4 ports; the next packet reaches port 0 only.
REQ-038 Assert reset during beat 2 of 4 -> all m_axis_tvalid=0 the next cycle and all counters=0; a following 1-beat packet gives pkt_cnt=1.
REQ-039 Preload counters to all-ones via a long packet run; one more packet -> pkt_cnt stays at all-ones; then cnt_clear coincident with a tlast handshake -> pkt_cnt=0.
